gate_tester: RTL and testbench

GATE_TESTER -- requirements
Module: gate_tester

---
 rtl/gate_tester_pkg.sv | 19 +
 rtl/gate_ref_model.sv | 14 +
 rtl/gate_tester.sv | 111 +++++++++++
 tb/tb_gate_tester.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/gate_tester_pkg.sv
// Shared types and constants for the gate_tester exhaustive 2-input gate checker.
package gate_tester_pkg;

   localparam int unsigned NUM_VECTORS = 4;
   localparam int unsigned ERR_CNT_W   = 3;
   localparam int unsigned IDX_W       = 2;

   localparam logic [ERR_CNT_W-1:0] ERR_MAX  = ERR_CNT_W'(NUM_VECTORS);
   localparam logic [IDX_W-1:0]     LAST_IDX = IDX_W'(NUM_VECTORS - 1);

   typedef enum logic [2:0] {
      StIdle,
      StDrive,
      StSettle,
      StCheck,
      StDone
   } state_e;

endpackage

// File: rtl/gate_ref_model.sv
// Golden AND/OR/NOT responses for the stimulus currently driven to the gate unit.
module gate_ref_model (
   input  logic a,
   input  logic b,
   output logic e1,
   output logic e2,
   output logic e3
);

   assign e1 = a & b;
   assign e2 = a | b;
   assign e3 = ~a;

endmodule

// File: rtl/gate_tester.sv
// Walks {a,b} through 00..11, waits SETTLE_CYCLES, and scores the gate's AND/OR/NOT outputs.
// Optional per-vector failure map enabled by defining GATE_TESTER_FAILVEC_EN.
module gate_tester
   import gate_tester_pkg::*;
#(
   parameter int unsigned SETTLE_CYCLES = 2
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   start,
   output logic                   a,
   output logic                   b,
   input  logic                   y1,
   input  logic                   y2,
   input  logic                   y3,
   output logic                   busy,
   output logic                   done,
   output logic                   pass,
`ifdef GATE_TESTER_FAILVEC_EN
   output logic [NUM_VECTORS-1:0] fail_vec,
`endif
   output logic [ERR_CNT_W-1:0]   err_cnt
);

   state_e           state_q;
   logic [IDX_W-1:0] idx_q;
   logic [3:0]       cnt_q;
   logic             e1, e2, e3;
   logic             mismatch;

   gate_ref_model u_ref (
      .a  (a),
      .b  (b),
      .e1 (e1),
      .e2 (e2),
      .e3 (e3)
   );

   // Default-to-fail so an X/Z response cannot slip through as a match.
   always_comb begin
      mismatch = 1'b1;
      if ({y3, y2, y1} == {e3, e2, e1}) mismatch = 1'b0;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= StIdle;
         idx_q    <= '0;
         cnt_q    <= '0;
         a        <= 1'b0;
         b        <= 1'b0;
         busy     <= 1'b0;
         done     <= 1'b0;
         pass     <= 1'b0;
         err_cnt  <= '0;
`ifdef GATE_TESTER_FAILVEC_EN
         fail_vec <= '0;
`endif
      end else begin
         unique case (state_q)
            StIdle, StDone: begin
               if (start) begin
                  state_q  <= StDrive;
                  idx_q    <= '0;
                  err_cnt  <= '0;
`ifdef GATE_TESTER_FAILVEC_EN
                  fail_vec <= '0;
`endif
                  busy     <= 1'b1;
                  done     <= 1'b0;
                  pass     <= 1'b0;
               end
            end
            StDrive: begin
               a <= idx_q[1];
               b <= idx_q[0];
               if (SETTLE_CYCLES == 0) begin
                  state_q <= StCheck;
               end else begin
                  cnt_q   <= 4'(SETTLE_CYCLES);
                  state_q <= StSettle;
               end
            end
            StSettle: begin
               cnt_q <= cnt_q - 4'd1;
               if (cnt_q == 4'd1) state_q <= StCheck;
            end
            StCheck: begin
               if (mismatch) begin
                  if (err_cnt < ERR_MAX) err_cnt <= err_cnt + 3'd1;
`ifdef GATE_TESTER_FAILVEC_EN
                  fail_vec[idx_q] <= 1'b1;
`endif
               end
               if (idx_q == LAST_IDX) begin
                  state_q <= StDone;
                  busy    <= 1'b0;
                  done    <= 1'b1;
                  // Final vector's result lands this edge, so fold it in directly.
                  pass    <= (err_cnt == '0) && !mismatch;
               end else begin
                  idx_q   <= idx_q + 2'd1;
                  state_q <= StDrive;
               end
            end
            default: state_q <= StIdle;
         endcase
      end
   end

endmodule

// File: tb/tb_gate_tester.sv
// Randomized fault-injection bench for gate_tester at SETTLE_CYCLES=2 and SETTLE_CYCLES=0.
module tb_gate_tester;
   import gate_tester_pkg::*;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       start;
   logic       a, b, y1, y2, y3, busy, done, pass;
   logic [2:0] err_cnt;
   logic       a0, b0, z1, z2, z3, busy0, done0, pass0;
   logic [2:0] err_cnt0;
`ifdef GATE_TESTER_FAILVEC_EN
   logic [3:0] fail_vec, fail_vec0;
`endif
   logic [2:0] flip [4];
   int         n_checks = 0;
   int         n_errors = 0;

   always #5 clk = ~clk;

   // Fault-free gate response packed as {NOT, OR, AND}.
   function automatic logic [2:0] ideal(input logic [1:0] v);
      return {~v[1], v[1] | v[0], v[1] & v[0]};
   endfunction

   assign {y3, y2, y1} = ideal({a, b}) ^ flip[{a, b}];
   assign {z3, z2, z1} = ideal({a0, b0}) ^ flip[{a0, b0}];

   gate_tester #(.SETTLE_CYCLES(2)) u_dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .start    (start),
      .a        (a),
      .b        (b),
      .y1       (y1),
      .y2       (y2),
      .y3       (y3),
      .busy     (busy),
      .done     (done),
      .pass     (pass),
`ifdef GATE_TESTER_FAILVEC_EN
      .fail_vec (fail_vec),
`endif
      .err_cnt  (err_cnt)
   );

   gate_tester #(.SETTLE_CYCLES(0)) u_dut0 (
      .clk      (clk),
      .rst_n    (rst_n),
      .start    (start),
      .a        (a0),
      .b        (b0),
      .y1       (z1),
      .y2       (z2),
      .y3       (z3),
      .busy     (busy0),
      .done     (done0),
      .pass     (pass0),
`ifdef GATE_TESTER_FAILVEC_EN
      .fail_vec (fail_vec0),
`endif
      .err_cnt  (err_cnt0)
   );

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
      end
   endtask

   // Reference: a vector fails when the faulty gate disagrees with the boolean rules.
   task automatic expect_result(output int e_err, output logic [3:0] e_fv);
      e_err = 0;
      e_fv  = '0;
      for (int v = 0; v < 4; v++) begin
         logic       va, vb;
         logic [2:0] obs, want;
         va   = v[1];
         vb   = v[0];
         obs  = ideal(2'(v)) ^ flip[v];
         want = {~va, va | vb, va & vb};
         if (obs != want) begin
            e_fv[v] = 1'b1;
            e_err++;
         end
      end
      if (e_err > 4) e_err = 4;
   endtask

   task automatic check_idle(input string tag);
      check_eq({tag, " s2 outs"}, {a, b, busy, done, pass, err_cnt}, '0);
      check_eq({tag, " s0 outs"}, {a0, b0, busy0, done0, pass0, err_cnt0}, '0);
`ifdef GATE_TESTER_FAILVEC_EN
      check_eq({tag, " fail_vec"}, {fail_vec, fail_vec0}, '0);
`endif
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      check_idle("reset");
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic run_pass(input string tag, input bit hold);
      int         e_err;
      logic [3:0] e_fv;
      expect_result(e_err, e_fv);
      start = 1'b1;
      for (int k = 1; k <= 17; k++) begin
         @(negedge clk);
         if (!hold && k == 1) start = 1'b0;
         if (k >= 2) check_eq({tag, " s2 ab"}, {a, b}, (k - 2) / 4);
         check_eq({tag, " s2 busy/done/pass"}, {busy, done, pass},
                  {k <= 16, k == 17, k == 17 && e_err == 0});
         if (k >= 2 && k <= 9) check_eq({tag, " s0 ab"}, {a0, b0}, (k - 2) / 2);
         if (k <= 9)
            check_eq({tag, " s0 busy/done/pass"}, {busy0, done0, pass0},
                     {k <= 8, k == 9, k == 9 && e_err == 0});
      end
      check_eq({tag, " s2 err_cnt"}, err_cnt, e_err);
`ifdef GATE_TESTER_FAILVEC_EN
      check_eq({tag, " s2 fail_vec"}, fail_vec, e_fv);
`endif
      if (!hold) begin
         check_eq({tag, " s0 err_cnt"}, err_cnt0, e_err);
         check_eq({tag, " s0 hold"}, {a0, b0, done0}, 3'b111);
`ifdef GATE_TESTER_FAILVEC_EN
         check_eq({tag, " s0 fail_vec"}, fail_vec0, e_fv);
`endif
      end else begin
         // start still high: the DONE state accepts it on the very next edge
         @(negedge clk);
         check_eq({tag, " restart"}, {busy, done, pass, err_cnt}, 6'b100000);
         start = 1'b0;
         do_reset();
      end
   endtask

   task automatic set_flips_clean();
      for (int v = 0; v < 4; v++) flip[v] = 3'b000;
   endtask

   initial begin
      rst_n = 1'b0;
      start = 1'b0;
      set_flips_clean();
      do_reset();

      run_pass("clean", 1'b0);

      for (int v = 0; v < 4; v++) begin
         logic va, vb;
         va = v[1];
         vb = v[0];
         flip[v] = {1'b0, (va | vb) ^ ~(va & vb), 1'b0};
      end
      run_pass("y2_nand", 1'b0);

      for (int v = 0; v < 4; v++) begin
         logic va;
         va = v[1];
         flip[v] = {~va, 2'b00};
      end
      run_pass("y3_stuck0", 1'b0);

      // Abort mid-pass, then a fresh pass must be complete and clean
      set_flips_clean();
      flip[2] = 3'b010;
      start = 1'b1;
      for (int k = 1; k <= 6; k++) begin
         @(negedge clk);
         start = 1'b0;
      end
      rst_n = 1'b0;
      #1;
      check_idle("abort");
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      check_idle("post_abort");
      set_flips_clean();
      run_pass("after_abort", 1'b0);

      run_pass("hold_start", 1'b1);

      for (int i = 0; i < 8; i++) begin
         for (int v = 0; v < 4; v++)
            flip[v] = ($urandom_range(0, 2) == 0) ? 3'($urandom_range(1, 7)) : 3'b000;
         if ($urandom_range(0, 1) == 1) do_reset();
         run_pass("random", 1'b0);
      end

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
